// File: rtl/pe_seq_pkg.sv
// ============================================================================
// pe_seq_pkg : shared state encodings and phase-skip helper for pe_job_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package pe_seq_pkg;

  typedef enum logic [1:0] {
    PH_FILT  = 2'd0,
    PH_IF    = 2'd1,
    PH_PSUM  = 2'd2,
    PH_RDONE = 2'd3
  } rd_phase_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KICK = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } top_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_POP  = 2'd1,
    W_CAP  = 2'd2,
    W_REQ  = 2'd3
  } wr_state_e;

  // First phase at or after 'from' whose word count is non-zero; nz = {psum, if, filt}.
  function automatic rd_phase_e phase_from(logic [2:0] from, logic [2:0] nz);
    rd_phase_e ph;
    ph = PH_RDONE;
    if (from <= 3'd2 && nz[2]) ph = PH_PSUM;
    if (from <= 3'd1 && nz[1]) ph = PH_IF;
    if (from == 3'd0 && nz[0]) ph = PH_FILT;
    return ph;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_seq_rd_engine.sv
// ============================================================================
// pe_seq_rd_engine : single-outstanding memory reader steering words into the PE input FIFOs
// Rev 1.0
// ============================================================================
`default_nettype none

module pe_seq_rd_engine
  import pe_seq_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8,
  parameter int IF_W   = 10,
  parameter int FILT_W = 8,
  parameter int PSUM_W = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              run_i,
  input  logic [ADDR_W-1:0] filt_base_i,
  input  logic [ADDR_W-1:0] if_base_i,
  input  logic [ADDR_W-1:0] psum_base_i,
  input  logic [CNT_W-1:0]  filt_cnt_i,
  input  logic [CNT_W-1:0]  if_cnt_i,
  input  logic [CNT_W-1:0]  psum_cnt_i,
  output logic              mem_rd_req_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic              mem_rd_gnt_i,
  input  logic              mem_rd_valid_i,
  input  logic [PSUM_W-1:0] mem_rd_data_i,
  output logic              filter_wen_o,
  output logic [FILT_W-1:0] filter_din_o,
  output logic              if_wen_o,
  output logic [IF_W-1:0]   if_din_o,
  output logic              psum_wen_o,
  output logic [PSUM_W-1:0] psum_din_o,
  input  logic              filter_full_i,
  input  logic              if_full_i,
  input  logic              psum_full_i,
  output logic              done_o
);

  rd_phase_e         phase_q;
  rd_phase_e         tag_q;
  logic [CNT_W-1:0]  idx_q;
  logic              req_q;
  logic              outst_q;
  logic [ADDR_W-1:0] addr_q;

  logic [ADDR_W-1:0] cur_base;
  logic [CNT_W-1:0]  cur_cnt;
  logic              cur_full;
  logic [2:0]        nz;
  logic              rsp;

  assign nz = {psum_cnt_i != '0, if_cnt_i != '0, filt_cnt_i != '0};

  always_comb begin
    cur_base = '0;
    cur_cnt  = '0;
    cur_full = 1'b1;
    case (phase_q)
      PH_FILT: begin cur_base = filt_base_i; cur_cnt = filt_cnt_i; cur_full = filter_full_i; end
      PH_IF:   begin cur_base = if_base_i;   cur_cnt = if_cnt_i;   cur_full = if_full_i;     end
      PH_PSUM: begin cur_base = psum_base_i; cur_cnt = psum_cnt_i; cur_full = psum_full_i;   end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      phase_q <= PH_FILT;
      tag_q   <= PH_FILT;
      idx_q   <= '0;
      req_q   <= 1'b0;
      outst_q <= 1'b0;
      addr_q  <= '0;
    end else if (start_i) begin
      phase_q <= phase_from(3'd0, nz);
      idx_q   <= '0;
      req_q   <= 1'b0;
      outst_q <= 1'b0;
    end else if (run_i) begin
      if (req_q) begin
        if (mem_rd_gnt_i) begin
          req_q   <= 1'b0;
          outst_q <= 1'b1;
          tag_q   <= phase_q;
        end
      end else if (outst_q) begin
        if (mem_rd_valid_i) begin
          outst_q <= 1'b0;
          if (idx_q + 1'b1 == cur_cnt) begin
            phase_q <= phase_from({1'b0, phase_q} + 3'd1, nz);
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
      end else if (phase_q != PH_RDONE && !cur_full) begin
        // FIFO space is checked here only; the PE is the sole consumer, so it cannot shrink.
        req_q  <= 1'b1;
        addr_q <= cur_base + ADDR_W'(idx_q);
      end
    end
  end

  // Steering follows the phase that issued the read, not the phase now current.
  assign rsp          = mem_rd_valid_i && outst_q;
  assign filter_wen_o = rsp && (tag_q == PH_FILT);
  assign if_wen_o     = rsp && (tag_q == PH_IF);
  assign psum_wen_o   = rsp && (tag_q == PH_PSUM);
  assign filter_din_o = mem_rd_data_i[FILT_W-1:0];
  assign if_din_o     = mem_rd_data_i[IF_W-1:0];
  assign psum_din_o   = mem_rd_data_i;

  assign mem_rd_req_o  = req_q;
  assign mem_rd_addr_o = addr_q;
  assign done_o        = (phase_q == PH_RDONE) && !req_q && !outst_q;

endmodule

`default_nettype wire

// File: rtl/pe_job_sequencer.sv
// ============================================================================
// pe_job_sequencer : job controller loading PE input FIFOs and draining results to memory
// Rev 1.0
// ============================================================================
`default_nettype none

module pe_job_sequencer
  import pe_seq_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8,
  parameter int IF_W   = 10,
  parameter int FILT_W = 8,
  parameter int PSUM_W = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [ADDR_W-1:0] cfg_filt_base_i,
  input  logic [ADDR_W-1:0] cfg_if_base_i,
  input  logic [ADDR_W-1:0] cfg_psum_base_i,
  input  logic [ADDR_W-1:0] cfg_out_base_i,
  input  logic [CNT_W-1:0]  cfg_filt_cnt_i,
  input  logic [CNT_W-1:0]  cfg_if_cnt_i,
  input  logic [CNT_W-1:0]  cfg_psum_cnt_i,
  input  logic [CNT_W-1:0]  cfg_out_cnt_i,
  output logic              mem_rd_req_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic              mem_rd_gnt_i,
  input  logic              mem_rd_valid_i,
  input  logic [PSUM_W-1:0] mem_rd_data_i,
  output logic              filter_wen_o,
  output logic              if_wen_o,
  output logic              psum_wen_o,
  output logic [FILT_W-1:0] filter_din_o,
  output logic [IF_W-1:0]   if_din_o,
  output logic [PSUM_W-1:0] psum_din_o,
  input  logic              filter_full_i,
  input  logic              if_full_i,
  input  logic              psum_full_i,
  output logic              pe_start_o,
  output logic              outbuf_ren_o,
  input  logic [PSUM_W-1:0] outbuf_dout_i,
  input  logic              outbuf_empty_i,
  output logic              mem_wr_req_o,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [PSUM_W-1:0] mem_wr_data_o,
  input  logic              mem_wr_gnt_i,
  output logic              busy_o,
  output logic              done_o
);

  top_state_e        state_q;
  logic              cfg_ready_q, busy_q, pe_start_q, done_q;
  logic [ADDR_W-1:0] filt_base_q, if_base_q, psum_base_q, out_base_q;
  logic [CNT_W-1:0]  filt_cnt_q, if_cnt_q, psum_cnt_q, out_cnt_q;

  wr_state_e         w_state_q;
  logic [CNT_W-1:0]  written_q;
  logic              ren_q, wr_req_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [PSUM_W-1:0] wr_data_q;

  logic rd_done, wr_done;

  assign wr_done = (w_state_q == W_IDLE) && (written_q == out_cnt_q);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      pe_start_q  <= 1'b0;
      done_q      <= 1'b0;
      filt_base_q <= '0;
      if_base_q   <= '0;
      psum_base_q <= '0;
      out_base_q  <= '0;
      filt_cnt_q  <= '0;
      if_cnt_q    <= '0;
      psum_cnt_q  <= '0;
      out_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (cfg_valid_i) begin
          filt_base_q <= cfg_filt_base_i;
          if_base_q   <= cfg_if_base_i;
          psum_base_q <= cfg_psum_base_i;
          out_base_q  <= cfg_out_base_i;
          filt_cnt_q  <= cfg_filt_cnt_i;
          if_cnt_q    <= cfg_if_cnt_i;
          psum_cnt_q  <= cfg_psum_cnt_i;
          out_cnt_q   <= cfg_out_cnt_i;
          cfg_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          pe_start_q  <= 1'b1;
          state_q     <= ST_KICK;
        end
        ST_KICK: begin
          pe_start_q <= 1'b0;
          state_q    <= ST_RUN;
        end
        ST_RUN: if (rd_done && wr_done) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_FIN;
        end
        default: begin
          done_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // Output drain: one word at a time, popped, captured the following cycle, then written.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      w_state_q <= W_IDLE;
      written_q <= '0;
      ren_q     <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (state_q == ST_KICK) begin
      w_state_q <= W_IDLE;
      written_q <= '0;
      ren_q     <= 1'b0;
      wr_req_q  <= 1'b0;
    end else if (state_q == ST_RUN) begin
      case (w_state_q)
        W_IDLE: if (!outbuf_empty_i && written_q < out_cnt_q) begin
          ren_q     <= 1'b1;
          w_state_q <= W_POP;
        end
        W_POP: begin
          ren_q     <= 1'b0;
          w_state_q <= W_CAP;
        end
        W_CAP: begin
          wr_data_q <= outbuf_dout_i;
          wr_addr_q <= out_base_q + ADDR_W'(written_q);
          wr_req_q  <= 1'b1;
          w_state_q <= W_REQ;
        end
        default: if (mem_wr_gnt_i) begin
          wr_req_q  <= 1'b0;
          written_q <= written_q + 1'b1;
          w_state_q <= W_IDLE;
        end
      endcase
    end
  end

  pe_seq_rd_engine #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .IF_W   (IF_W),
    .FILT_W (FILT_W),
    .PSUM_W (PSUM_W)
  ) u_rd_engine (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .start_i        (state_q == ST_KICK),
    .run_i          (state_q == ST_RUN),
    .filt_base_i    (filt_base_q),
    .if_base_i      (if_base_q),
    .psum_base_i    (psum_base_q),
    .filt_cnt_i     (filt_cnt_q),
    .if_cnt_i       (if_cnt_q),
    .psum_cnt_i     (psum_cnt_q),
    .mem_rd_req_o   (mem_rd_req_o),
    .mem_rd_addr_o  (mem_rd_addr_o),
    .mem_rd_gnt_i   (mem_rd_gnt_i),
    .mem_rd_valid_i (mem_rd_valid_i),
    .mem_rd_data_i  (mem_rd_data_i),
    .filter_wen_o   (filter_wen_o),
    .filter_din_o   (filter_din_o),
    .if_wen_o       (if_wen_o),
    .if_din_o       (if_din_o),
    .psum_wen_o     (psum_wen_o),
    .psum_din_o     (psum_din_o),
    .filter_full_i  (filter_full_i),
    .if_full_i      (if_full_i),
    .psum_full_i    (psum_full_i),
    .done_o         (rd_done)
  );

  assign cfg_ready_o   = cfg_ready_q;
  assign busy_o        = busy_q;
  assign pe_start_o    = pe_start_q;
  assign done_o        = done_q;
  assign outbuf_ren_o  = ren_q;
  assign mem_wr_req_o  = wr_req_q;
  assign mem_wr_addr_o = wr_addr_q;
  assign mem_wr_data_o = wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_job_sequencer.sv
// ============================================================================
// tb_pe_job_sequencer : directed scoreboard bench with a behavioural memory and output FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pe_job_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] filt_base = '0, if_base = '0, psum_base = '0, out_base = '0;
  logic [7:0]  filt_cnt = '0, if_cnt = '0, psum_cnt = '0, out_cnt = '0;
  logic        mem_rd_req;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_gnt = 1'b0, mem_rd_valid = 1'b0;
  logic [15:0] mem_rd_data = '0;
  logic        filter_wen, if_wen, psum_wen;
  logic [7:0]  filter_din;
  logic [9:0]  if_din;
  logic [15:0] psum_din;
  logic        filter_full = 1'b0, if_full = 1'b0, psum_full = 1'b0;
  logic        pe_start, outbuf_ren;
  logic [15:0] outbuf_dout = '0;
  logic        outbuf_empty = 1'b1;
  logic        mem_wr_req;
  logic [15:0] mem_wr_addr, mem_wr_data;
  logic        mem_wr_gnt = 1'b0;
  logic        busy, done;

  always #5 clk = ~clk;

  pe_job_sequencer dut (
    .clk_i(clk), .rstn_i(rstn),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_filt_base_i(filt_base), .cfg_if_base_i(if_base),
    .cfg_psum_base_i(psum_base), .cfg_out_base_i(out_base),
    .cfg_filt_cnt_i(filt_cnt), .cfg_if_cnt_i(if_cnt),
    .cfg_psum_cnt_i(psum_cnt), .cfg_out_cnt_i(out_cnt),
    .mem_rd_req_o(mem_rd_req), .mem_rd_addr_o(mem_rd_addr),
    .mem_rd_gnt_i(mem_rd_gnt), .mem_rd_valid_i(mem_rd_valid), .mem_rd_data_i(mem_rd_data),
    .filter_wen_o(filter_wen), .if_wen_o(if_wen), .psum_wen_o(psum_wen),
    .filter_din_o(filter_din), .if_din_o(if_din), .psum_din_o(psum_din),
    .filter_full_i(filter_full), .if_full_i(if_full), .psum_full_i(psum_full),
    .pe_start_o(pe_start), .outbuf_ren_o(outbuf_ren),
    .outbuf_dout_i(outbuf_dout), .outbuf_empty_i(outbuf_empty),
    .mem_wr_req_o(mem_wr_req), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
    .mem_wr_gnt_i(mem_wr_gnt), .busy_o(busy), .done_o(done)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t         rd_exp[$], rd_obs[$], wr_exp[$], wr_obs[$];
  logic [15:0] outbuf_q[$];
  logic [15:0] gnt_log[$];
  int checks = 0, failures = 0;

  logic        rd_gnt_en = 1'b1, wr_gnt_en = 1'b1, win = 1'b0;
  logic        pend = 1'b0;
  logic [15:0] pend_addr = '0, resp_addr = '0;
  int filt_n = 0, if_n = 0, psum_n = 0, start_n = 0, done_n = 0, ren_n = 0, req_win_n = 0;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  // Memory and output-FIFO models plus event monitor.
  always @(negedge clk) begin
    if (pend) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = memf(pend_addr);
      resp_addr    = pend_addr;
      pend         = 1'b0;
    end else begin
      mem_rd_valid = 1'b0;
    end
    mem_rd_gnt = mem_rd_req && rd_gnt_en;
    if (mem_rd_gnt) begin
      pend      = 1'b1;
      pend_addr = mem_rd_addr;
      gnt_log.push_back(mem_rd_addr);
    end
    if (outbuf_ren) begin
      ren_n++;
      if (outbuf_q.size() > 0) outbuf_dout = outbuf_q.pop_front();
    end
    outbuf_empty = (outbuf_q.size() == 0);
    mem_wr_gnt = mem_wr_req && wr_gnt_en;
    if (mem_wr_gnt) wr_obs.push_back({2'd3, mem_wr_addr, mem_wr_data});
    #1;
    if (filter_wen) begin filt_n++; rd_obs.push_back({2'd0, resp_addr, 8'h00, filter_din}); end
    if (if_wen)     begin if_n++;   rd_obs.push_back({2'd1, resp_addr, 6'h00, if_din}); end
    if (psum_wen)   begin psum_n++; rd_obs.push_back({2'd2, resp_addr, psum_din}); end
    if (pe_start) start_n++;
    if (done) done_n++;
    if (win && mem_rd_req) req_win_n++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [15:0] fb, ib, pb, ob, input int fc, ic, pc, oc);
    logic [15:0] a, w;
    for (int i = 0; i < fc; i++) begin a = fb + 16'(i); rd_exp.push_back({2'd0, a, memf(a) & 16'h00FF}); end
    for (int i = 0; i < ic; i++) begin a = ib + 16'(i); rd_exp.push_back({2'd1, a, memf(a) & 16'h03FF}); end
    for (int i = 0; i < pc; i++) begin a = pb + 16'(i); rd_exp.push_back({2'd2, a, memf(a)}); end
    for (int i = 0; i < oc; i++) begin
      w = 16'($urandom);
      outbuf_q.push_back(w);
      wr_exp.push_back({2'd3, ob + 16'(i), w});
    end
    filt_base = fb; if_base = ib; psum_base = pb; out_base = ob;
    filt_cnt = 8'(fc); if_cnt = 8'(ic); psum_cnt = 8'(pc); out_cnt = 8'(oc);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    #2;
    chk("pe_start_after_accept", {pe_start, busy, cfg_ready}, 3'b110);
  endtask

  task automatic wait_done(input string tag);
    int d0;
    d0 = done_n;
    for (int c = 0; c < 2000 && done_n == d0; c++) @(negedge clk);
    #2;
    chk({tag, "_done_pulse"}, 64'(done_n - d0), 64'd1);
    chk({tag, "_idle_after_done"}, {cfg_ready, busy, done}, 3'b100);
  endtask

  task automatic sb_check(input string tag);
    chk({tag, "_rd_count"}, 64'(rd_obs.size()), 64'(rd_exp.size()));
    while (rd_exp.size() > 0 && rd_obs.size() > 0) chk({tag, "_rd_word"}, 64'(rd_obs.pop_front()), 64'(rd_exp.pop_front()));
    chk({tag, "_wr_count"}, 64'(wr_obs.size()), 64'(wr_exp.size()));
    while (wr_exp.size() > 0 && wr_obs.size() > 0) chk({tag, "_wr_word"}, 64'(wr_obs.pop_front()), 64'(wr_exp.pop_front()));
    rd_exp.delete(); rd_obs.delete(); wr_exp.delete(); wr_obs.delete();
  endtask

  initial begin
    int s0, n0, r0, g0, w0;
    logic [15:0] a0, d0;
    logic [15:0] wrap_exp[4];
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outputs", {cfg_ready, busy, mem_rd_req, mem_wr_req, pe_start, done, outbuf_ren, mem_rd_addr},
        {7'b1000000, 16'h0000});
    rstn = 1'b1;
    @(negedge clk);

    // Basic job with one surplus word left in the output FIFO
    s0 = start_n;
    start_job(16'h0100, 16'h0200, 16'h0300, 16'h0800, 3, 4, 2, 2);
    outbuf_q.push_back(16'hDEAD);
    wait_done("basic");
    chk("basic_single_start", 64'(start_n - s0), 64'd1);
    chk("basic_extra_word_left", 64'(outbuf_q.size()), 64'd1);
    outbuf_q.delete();
    sb_check("basic");

    // IF FIFO backpressure
    start_job(16'h0000, 16'h2000, 16'h3000, 16'h0000, 0, 8, 1, 0);
    n0 = if_n;
    for (int c = 0; c < 200 && if_n < n0 + 3; c++) @(negedge clk);
    chk("bp_reached_mid_if", 64'(if_n >= n0 + 3), 64'd1);
    if_full = 1'b1;
    repeat (3) @(negedge clk);
    n0 = if_n;
    req_win_n = 0;
    win = 1'b1;
    repeat (10) @(negedge clk);
    win = 1'b0;
    chk("bp_no_req_while_full", 64'(req_win_n), 64'd0);
    chk("bp_no_if_write_while_full", 64'(if_n - n0), 64'd0);
    if_full = 1'b0;
    wait_done("bp");
    sb_check("bp");

    // Zero-count phases skipped
    n0 = filt_n + psum_n;
    start_job(16'h0040, 16'h4000, 16'h0050, 16'h4100, 0, 3, 0, 1);
    wait_done("zero");
    chk("zero_no_filt_psum", 64'(filt_n + psum_n - n0), 64'd0);
    sb_check("zero");

    // Write grant stall
    wr_gnt_en = 1'b0;
    start_job(16'h0400, 16'h0500, 16'h0000, 16'h0A00, 1, 1, 0, 3);
    for (int c = 0; c < 200 && !mem_wr_req; c++) @(negedge clk);
    #2;
    chk("stall_wr_req_seen", 64'(mem_wr_req), 64'd1);
    a0 = mem_wr_addr; d0 = mem_wr_data; r0 = ren_n;
    chk("stall_first_addr", 64'(a0), 64'h0A00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #2;
      chk("stall_wr_hold", {mem_wr_req, mem_wr_addr, mem_wr_data}, {1'b1, a0, d0});
    end
    chk("stall_no_extra_ren", 64'(ren_n - r0), 64'd0);
    wr_gnt_en = 1'b1;
    wait_done("stall");
    sb_check("stall");

    // Address wrap
    g0 = gnt_log.size();
    start_job(16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 0, 4, 0, 0);
    wait_done("wrap");
    chk("wrap_grant_count", 64'(gnt_log.size() - g0), 64'd4);
    for (int i = 0; i < 4; i++)
      if (g0 + i < gnt_log.size()) chk("wrap_addr", 64'(gnt_log[g0 + i]), 64'(wrap_exp[i]));
    sb_check("wrap");

    // Reset while a read response is pending
    g0 = gnt_log.size();
    start_job(16'h0000, 16'h6000, 16'h0000, 16'h0000, 0, 4, 0, 0);
    do begin @(negedge clk); #2; end while (gnt_log.size() == g0 && busy);
    chk("rst_grant_seen", 64'(gnt_log.size() > g0), 64'd1);
    w0 = filt_n + if_n + psum_n;
    @(negedge clk);
    rstn = 1'b0;
    #2;
    chk("rst_mid_outputs", {cfg_ready, busy, mem_rd_req, mem_wr_req, pe_start, done, outbuf_ren, mem_rd_addr},
        {7'b1000000, 16'h0000});
    repeat (3) @(negedge clk);
    chk("rst_late_valid_dropped", 64'(filt_n + if_n + psum_n - w0), 64'd0);
    rd_exp.delete(); rd_obs.delete();
    rstn = 1'b1;
    @(negedge clk);

    // Recovery job after the abandoned one
    start_job(16'h7000, 16'h0000, 16'h0000, 16'h7100, 2, 0, 0, 1);
    wait_done("recover");
    sb_check("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
